key_click_decoder: RTL and testbench
====================================

# key_click_decoder

Multi-click classifier sitting directly downstream of the key debouncer. Consumes its one-cycle "press captured" pulse and groups presses that arrive within a sliding time window into a single event carrying the click count (single, double, triple, …). Events are held on a valid/ready output until a consumer, such as a menu or mode-select FSM, accepts them.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: clk_i frequency in Hz.
- `WINDOW_MS`, 300: inter-press window in ms. `WINDOW_CYCLES = CLK_FREQ/1000*WINDOW_MS`; must be ≥ 2.
- `MAX_CLICKS`, 3: click count that ends a sequence immediately. Legal range is 1..7.

Ports:
- `clk_i`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `press_i`, input, 1: one-cycle press pulse from the debouncer, synchronous to clk_i.
- `evt_valid_o`, output, 1: event pending.
- `evt_count_o`, output, 3: click count of the pending event (1..MAX_CLICKS). Valid only while evt_valid_o is high.
- `evt_ready_i`, input, 1: consumer accepts the event.
- `drop_o`, output, 1: one-cycle pulse when a press is discarded.
- `drop_cnt_o`, output, 8: saturating count of discarded presses (see Configuration).

## Operation
- Registered state machine with states IDLE, COUNT and REPORT. Internal registers:
  - `cnt[2:0]`: click count.
  - `timer`: width `$clog2(WINDOW_CYCLES)`.
- IDLE:
  - press_i → `cnt=1`, `timer=0`. Go to COUNT, or go directly to REPORT if MAX_CLICKS==1.
- COUNT, evaluated in priority order:
  - press_i and `cnt+1==MAX_CLICKS` → `cnt=MAX_CLICKS`, go to REPORT.
  - press_i otherwise → `cnt=cnt+1`, `timer=0`, stay in COUNT.
  - `timer==WINDOW_CYCLES-1` → go to REPORT.
  - Otherwise → `timer=timer+1`.
  - If a press and the timeout occur on the same edge, the press wins and the window restarts.
- REPORT:
  - `evt_valid_o=1` and `evt_count_o=cnt`, both stable until the handshake.
  - `evt_valid_o & evt_ready_i` sampled on an edge → handshake completes and the state returns to IDLE.
  - A press on the handshake edge is not dropped. It starts a new sequence (`cnt=1`, `timer=0`, go to COUNT).
  - A press in REPORT without a handshake on that edge is discarded. `drop_o` pulses high for the next cycle.
- evt_ready_i is ignored outside REPORT.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
- Reset values: state=IDLE, cnt=0, timer=0, `evt_valid_o=0`, `evt_count_o=0`, `drop_o=0`, `drop_cnt_o=0`.
- Asserting `rst` mid-sequence or mid-REPORT aborts immediately. The pending event is lost, and no event is emitted after reset deasserts.
- Timeout latency: the last press is sampled on edge t → `evt_valid_o` rises after edge `t+WINDOW_CYCLES`.
- Max-count latency: the press that reaches MAX_CLICKS is sampled on edge t → `evt_valid_o` rises after edge t.
- Handshake latency: handshake on edge h → `evt_valid_o` is low after edge h. The earliest next event is 1 cycle later, when MAX_CLICKS==1 and a press arrives on edge h+1.
- The window is measured from the most recent press, not the first.
- `drop_o` is high for exactly one cycle per discarded press. Back-to-back discards give back-to-back pulses.

## Configuration
- `KEY_CLICK_DROP_CNT_EN` defined:
  - `drop_cnt_o` increments by 1 on every `drop_o` pulse.
  - It saturates at 255 and is cleared only by `rst`.
- Not defined:
  - The counter register is not built and `drop_cnt_o` is tied to 0.
  - `drop_o` behaves identically in both builds.

## Test plan
Bench parameters: `CLK_FREQ=10_000`, `WINDOW_MS=2` (WINDOW_CYCLES=20), `MAX_CLICKS=3`, evt_ready_i held high unless stated otherwise.
- Single press on edge 10 → `evt_valid_o` high after edge 30, `evt_count_o=1`, one-cycle valid; no other event.
- Presses on edges 10 and 25 → one event after edge 45 with count 2.
- Presses on edges 10, 15 and 20 → event after edge 20 with count 3. No timeout event follows.
- Press exactly on the timeout edge: presses at 10 and 30 → count 2, event after edge 50.
- evt_ready_i low, 3 presses to reach REPORT, then 2 more presses → valid is held with count 3, and `drop_o` pulses twice. With the macro, `drop_cnt_o=2`. Then ready is raised on the same edge as a press → handshake completes and a new sequence with count 1 reports 20 cycles later.
- `rst` pulsed 5 cycles after the first press → all outputs return to 0, and no event appears within 40 cycles.

Source files
------------

// File: rtl/key_click_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_click_decoder: groups debounced press pulses into multi-click events |
// | Optional: KEY_CLICK_DROP_CNT_EN builds the saturating drop counter.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_click_decoder #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int WINDOW_MS  = 300,
    parameter int MAX_CLICKS = 3
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic       press_i,
    output logic       evt_valid_o,
    output logic [2:0] evt_count_o,
    input  logic       evt_ready_i,
    output logic       drop_o,
    output logic [7:0] drop_cnt_o
);

    localparam int WINDOW_CYCLES = CLK_FREQ / 1000 * WINDOW_MS;
    localparam int TIMER_W       = $clog2(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0] c_TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [3:0]         c_MAX        = 4'(MAX_CLICKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic [TIMER_W-1:0] r_timer;
    logic               r_evt_valid;
    logic [2:0]         r_evt_count;
    logic               r_drop;

    logic [3:0] w_cnt_inc;
    logic       w_reach_max;

    // Widened by one bit so the compare stays correct at MAX_CLICKS == 7
    assign w_cnt_inc   = {1'b0, r_cnt} + 4'd1;
    assign w_reach_max = (w_cnt_inc >= c_MAX);

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_timer     <= '0;
            r_evt_valid <= 1'b0;
            r_evt_count <= 3'd0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (press_i) begin
                        r_cnt   <= 3'd1;
                        r_timer <= '0;
                        if (MAX_CLICKS == 1) begin
                            r_state     <= S_REPORT;
                            r_evt_valid <= 1'b1;
                            r_evt_count <= 3'd1;
                        end else begin
                            r_state <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    // A press on the timeout edge wins and restarts the window
                    if (press_i && w_reach_max) begin
                        r_cnt       <= c_MAX[2:0];
                        r_state     <= S_REPORT;
                        r_evt_valid <= 1'b1;
                        r_evt_count <= c_MAX[2:0];
                    end else if (press_i) begin
                        r_cnt   <= w_cnt_inc[2:0];
                        r_timer <= '0;
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_state     <= S_REPORT;
                        r_evt_valid <= 1'b1;
                        r_evt_count <= r_cnt;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                S_REPORT: begin
                    if (evt_ready_i) begin
                        r_evt_valid <= 1'b0;
                        if (press_i) begin
                            r_cnt   <= 3'd1;
                            r_timer <= '0;
                            r_state <= S_COUNT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (press_i) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_evt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid_o = r_evt_valid;
    assign evt_count_o = r_evt_count;
    assign drop_o      = r_drop;

`ifdef KEY_CLICK_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 8'd0;
        end else if (r_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_click_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_key_click_decoder: directed self-checking bench for key_click_decoder |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_key_click_decoder;

    logic       clk_i;
    logic       rst;
    logic       press_i;
    logic       evt_valid_o;
    logic [2:0] evt_count_o;
    logic       evt_ready_i;
    logic       drop_o;
    logic [7:0] drop_cnt_o;

    int vectors;
    int miscompares;

    key_click_decoder #(
        .CLK_FREQ   (10_000),
        .WINDOW_MS  (2),
        .MAX_CLICKS (3)
    ) dut (
        .clk_i       (clk_i),
        .rst         (rst),
        .press_i     (press_i),
        .evt_valid_o (evt_valid_o),
        .evt_count_o (evt_count_o),
        .evt_ready_i (evt_ready_i),
        .drop_o      (drop_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive inputs for one edge, then return 1 time unit after that edge
    task automatic drive_cycle(input logic press, input logic ready);
        press_i     = press;
        evt_ready_i = ready;
        @(posedge clk_i);
        #1;
        press_i = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        press_i     = 1'b0;
        evt_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if (evt_valid_o !== 1'b0 || evt_count_o !== 3'd0 || drop_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
            miscompares++;
            $display("FAIL reset: valid=%b count=%0d drop=%b drop_cnt=%0d, required all 0",
                     evt_valid_o, evt_count_o, drop_o, drop_cnt_o);
        end
        rst = 1'b0;
        drive_cycle(1'b0, 1'b1);
    endtask

    // Generic window scenario: presses at listed edges, one event expected
    task automatic test_window(input string name, input int p0, input int p1, input int p2,
                               input int exp_edge, input logic [2:0] exp_count, input int n_edges);
        logic exp_valid;
        for (int e = 1; e <= n_edges; e++) begin
            drive_cycle((e == p0) || (e == p1) || (e == p2), 1'b1);
            exp_valid = (e == exp_edge);
            vectors++;
            if (evt_valid_o !== exp_valid) begin
                miscompares++;
                $display("FAIL %s valid edge %0d: got %b, required %b", name, e, evt_valid_o, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (evt_count_o !== exp_count) begin
                    miscompares++;
                    $display("FAIL %s count edge %0d: got %0d, required %0d", name, e, evt_count_o, exp_count);
                end
            end
        end
    endtask

    task automatic test_single();
        test_window("single", 10, -1, -1, 30, 3'd1, 60);
    endtask

    task automatic test_double();
        test_window("double", 10, 25, -1, 45, 3'd2, 70);
    endtask

    task automatic test_max_clicks();
        test_window("max_clicks", 10, 15, 20, 20, 3'd3, 60);
    endtask

    task automatic test_timeout_edge_press();
        test_window("timeout_edge", 10, 30, -1, 50, 3'd2, 75);
    endtask

    // Ready low: REPORT held, two back-to-back presses dropped, then
    // ready rises together with a press which starts a new sequence.
    task automatic test_back_to_back();
        logic       exp_valid;
        logic       exp_drop;
        logic [2:0] exp_count;
        logic [7:0] exp_dcnt;
        for (int e = 1; e <= 55; e++) begin
            drive_cycle((e == 10) || (e == 11) || (e == 12) || (e == 15) || (e == 16) || (e == 20),
                        (e >= 20));
            exp_valid = ((e >= 12) && (e < 20)) || (e == 40);
            exp_count = (e < 20) ? 3'd3 : 3'd1;
            exp_drop  = (e == 15) || (e == 16);
            vectors++;
            if (evt_valid_o !== exp_valid) begin
                miscompares++;
                $display("FAIL hold valid edge %0d: got %b, required %b", e, evt_valid_o, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (evt_count_o !== exp_count) begin
                    miscompares++;
                    $display("FAIL hold count edge %0d: got %0d, required %0d", e, evt_count_o, exp_count);
                end
            end
            vectors++;
            if (drop_o !== exp_drop) begin
                miscompares++;
                $display("FAIL drop_o edge %0d: got %b, required %b", e, drop_o, exp_drop);
            end
            if (e == 14 || e == 19 || e == 55) begin
`ifdef KEY_CLICK_DROP_CNT_EN
                exp_dcnt = (e == 14) ? 8'd0 : 8'd2;
`else
                exp_dcnt = 8'd0;
`endif
                vectors++;
                if (drop_cnt_o !== exp_dcnt) begin
                    miscompares++;
                    $display("FAIL drop_cnt edge %0d: got %0d, required %0d", e, drop_cnt_o, exp_dcnt);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int e = 1; e <= 15; e++) begin
            drive_cycle(e == 10, 1'b1);
        end
        rst = 1'b1;
        #3;
        vectors++;
        if (evt_valid_o !== 1'b0 || evt_count_o !== 3'd0 || drop_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b count=%0d drop=%b drop_cnt=%0d, required all 0",
                     evt_valid_o, evt_count_o, drop_o, drop_cnt_o);
        end
        @(posedge clk_i);
        #1;
        rst = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            drive_cycle(1'b0, 1'b1);
            vectors++;
            if (evt_valid_o !== 1'b0 || drop_o !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset edge %0d: valid=%b drop=%b, required 0 0", e, evt_valid_o, drop_o);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_double();
        test_max_clicks();
        test_timeout_edge_press();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
